conv_frame_ctrl: RTL

//  Store-and-forward frame sequencer for the rate-1/2, K=3 (7,5) convolutional encoder.

---
 rtl/conv_ctrl_pkg.sv | 18 +
 rtl/conv_frame_buf.sv | 38 +++
 rtl/conv_frame_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/conv_ctrl_pkg.sv
// Package: conv_ctrl_pkg
// Shared types and constants for the convolutional-encoder frame sequencer.
//   conv_ctrl_state_t : sequencer states (IDLE, FLUSH, ENCODE, TAIL)
//   BYTE_W            : payload byte width
//   TAIL_BITS         : zero bits appended to return a K=3 encoder to state 00
package conv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        ENCODE = 2'd2,
        TAIL   = 2'd3
    } conv_ctrl_state_t;

    localparam int BYTE_W    = 8;
    localparam int TAIL_BITS = 2;

endpackage

// File: rtl/conv_frame_buf.sv
// Module: conv_frame_buf
// Frame buffer for the sequencer: DEPTH x BYTE_W simple dual-port RAM,
// synchronous write, registered (1-cycle) synchronous read.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write byte
//   rd_en    in   read strobe; rd_data updates on the following edge
//   rd_addr  in   read address
//   rd_data  out  registered read byte, held while rd_en is low
module conv_frame_buf
    import conv_ctrl_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BYTE_W-1:0] rd_data
);

    logic [BYTE_W-1:0] mem [0:DEPTH-1];

    // The read register only moves on rd_en so the sequencer can serialise
    // the current byte for eight cycles without re-reading it.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/conv_frame_ctrl.sv
// Module: conv_frame_ctrl
// Store-and-forward frame sequencer for an external rate-1/2, K=3 (7,5)
// convolutional encoder. A byte frame is buffered, the encoder is cleared,
// the payload is streamed MSB-first one bit per cycle without gaps, and the
// encoder's 2-bit symbols are framed with valid/sop/eop.
// Build option:
//   CONV_CTRL_TAIL_EN  defined   -> two zero tail bits terminate the trellis
//                                   (8N+2 symbols per frame)
//                      undefined -> ENCODE returns straight to IDLE (8N symbols)
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   s_data/s_valid/s_last  byte source; s_ready accepts a byte (IDLE only)
//   enc_reset, enc_din     encoder clear and serial data
//   enc_dout               encoder registered output ([0]=g111, [1]=g101)
//   m_sym/m_valid/m_sop/m_eop  framed symbol stream, no backpressure
//   busy                   high in every state but IDLE
//   frame_len              byte count of the current/last frame
//   err_ovf                one-cycle pulse when a frame is cut at MAX_BYTES
module conv_frame_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int MAX_BYTES = 64,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              enc_reset,
    output logic              enc_din,
    input  logic [1:0]        enc_dout,
    output logic [1:0]        m_sym,
    output logic              m_valid,
    output logic              m_sop,
    output logic              m_eop,
    output logic              busy,
    output logic [LEN_W-1:0]  frame_len,
    output logic              err_ovf
);

    localparam int               ADDR_W  = $clog2(MAX_BYTES);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LAST_WR = LEN_W'(MAX_BYTES - 1);

    conv_ctrl_state_t  state;
    logic [LEN_W-1:0]  wr_cnt;
    logic [LEN_W-1:0]  rd_cnt;
    logic [2:0]        bit_idx;
    logic [BYTE_W-1:0] rd_data;
    logic              accept;
    logic              last_byte;
    logic              last_bit;
    logic              rd_en;
    logic              drv_valid;
    logic              drv_sop;
    logic              drv_eop;
`ifdef CONV_CTRL_TAIL_EN
    logic              tail_cnt;
`endif

    assign s_ready   = (state == IDLE) && !reset;
    assign busy      = (state != IDLE);
    assign enc_reset = reset || (state == IDLE) || (state == FLUSH);
    assign accept    = s_valid && s_ready;

    // A full buffer closes the frame even without s_last.
    assign last_byte = s_last || (wr_cnt == LAST_WR);

    // rd_cnt counts bytes already fetched, so the last payload bit is bit 0
    // once every byte of the frame has been read.
    assign last_bit  = (state == ENCODE) && (bit_idx == 3'd0) && (rd_cnt == frame_len);

    // Prefetch byte 0 in FLUSH, then fetch the next byte during bit 0 of the
    // current one so its bit 7 is ready on the very next cycle.
    assign rd_en     = (state == FLUSH) ||
                       ((state == ENCODE) && (bit_idx == 3'd0) && (rd_cnt != frame_len));

    assign enc_din   = (state == ENCODE) ? rd_data[bit_idx] : 1'b0;

    conv_frame_buf #(
        .DEPTH  (MAX_BYTES),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wr_cnt[ADDR_W-1:0]),
        .wr_data (s_data),
        .rd_en   (rd_en),
        .rd_addr (rd_cnt[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    // Flags describing the bit being driven into the encoder this cycle.
    always_comb begin
        drv_valid = (state == ENCODE) || (state == TAIL);
        drv_sop   = (state == ENCODE) && (rd_cnt == LEN_ONE) && (bit_idx == 3'd7);
`ifdef CONV_CTRL_TAIL_EN
        drv_eop   = (state == TAIL) && tail_cnt;
`else
        drv_eop   = last_bit;
`endif
    end

    // Sequencer: buffer a frame in IDLE, clear the encoder in FLUSH,
    // serialise the payload in ENCODE and optionally flush the trellis in TAIL.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            bit_idx   <= 3'd7;
            frame_len <= '0;
            err_ovf   <= 1'b0;
`ifdef CONV_CTRL_TAIL_EN
            tail_cnt  <= 1'b0;
`endif
        end else begin
            err_ovf <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (last_byte) begin
                            state     <= FLUSH;
                            frame_len <= wr_cnt + LEN_ONE;
                            err_ovf   <= !s_last;
                            wr_cnt    <= '0;
                            rd_cnt    <= '0;
                        end else begin
                            wr_cnt    <= wr_cnt + LEN_ONE;
                        end
                    end
                end
                FLUSH: begin
                    state   <= ENCODE;
                    rd_cnt  <= LEN_ONE;
                    bit_idx <= 3'd7;
                end
                ENCODE: begin
                    bit_idx <= bit_idx - 3'd1;
                    if (last_bit) begin
`ifdef CONV_CTRL_TAIL_EN
                        state    <= TAIL;
                        tail_cnt <= 1'b0;
`else
                        state    <= IDLE;
`endif
                    end else if (rd_en) begin
                        rd_cnt <= rd_cnt + LEN_ONE;
                    end
                end
`ifdef CONV_CTRL_TAIL_EN
                TAIL: begin
                    tail_cnt <= 1'b1;
                    if (tail_cnt == 1'(TAIL_BITS - 1))
                        state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // The encoder registers its output, so the drive flags are delayed one
    // cycle to line up with enc_dout; this drains regardless of state.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_sop   <= 1'b0;
            m_eop   <= 1'b0;
        end else begin
            m_valid <= drv_valid;
            m_sop   <= drv_sop;
            m_eop   <= drv_eop;
        end
    end

    assign m_sym = m_valid ? enc_dout : 2'b00;

endmodule
